// File: rtl/program_loader_pkg.sv
// Shared definitions for the boot-time program loader.
//   loaderState_t : loader FSM states, in frame order
//   INSTR_W       : instruction word width (3 bytes packed into 18 bits)
//   SYNC_BYTE     : frame start marker
package program_loader_pkg;

    typedef enum logic [3:0] {
        IDLE,
        LEN_HI,
        LEN_LO,
        B0,
        B1,
        B2,
        WRITE,
        CSUM,
        DONE,
        ERROR
    } loaderState_t;

    localparam int          INSTR_W   = 18;
    localparam logic [7:0]  SYNC_BYTE = 8'hA5;

endpackage

// File: rtl/program_loader.sv
// Boot-time program loader. Receives a framed byte stream
//   SYNC, LEN_HI, LEN_LO, N x (B0,B1,B2), CSUM
// packs each byte triple into an 18-bit instruction and writes it to program
// memory from address 0. The CPU is held in reset until the full image has
// been written and its checksum verified.
// Ports:
//   i_clock, i_reset          : clock, asynchronous active-high reset
//   i_rx_data/valid, o_rx_ready : byte stream in (bit 0 = MSB), valid/ready handshake
//   i_restart                 : pulse that re-arms the loader from DONE/ERROR
//   o_wr_en/addr/data         : program memory write port, one strobe per word
//   o_cpu_hold                : 1 = CPU held in reset
//   o_done, o_error           : image verified / framing, length or checksum failure
module program_loader
    import program_loader_pkg::*;
#(
    parameter int ADDR_W    = 16,
    parameter int MAX_WORDS = 4096
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic [0:7]        i_rx_data,
    input  logic              i_rx_valid,
    output logic              o_rx_ready,
    input  logic              i_restart,
    output logic              o_wr_en,
    output logic [0:ADDR_W-1] o_wr_addr,
    output logic [0:INSTR_W-1] o_wr_data,
    output logic              o_cpu_hold,
    output logic              o_done,
    output logic              o_error
);

    loaderState_t state;
    logic [7:0]   lenHi;
    logic [15:0]  length;
    logic [16:0]  wordCount;   // one bit wider than N so the count can reach MAX_WORDS
    logic [7:0]   checksum;
    logic [0:1]   b0Low;
    logic [0:7]   b1Byte;
    logic         rxFire;

    assign rxFire = i_rx_valid && o_rx_ready;

    // NOTE: every register here is state, so all assignments are non-blocking;
    // a blocking write would let later branches see the new value in the same edge.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state      <= IDLE;
            lenHi      <= '0;
            length     <= '0;
            wordCount  <= '0;
            checksum   <= '0;
            b0Low      <= '0;
            b1Byte     <= '0;
            o_rx_ready <= 1'b1;
            o_wr_en    <= 1'b0;
            o_wr_addr  <= '0;
            o_wr_data  <= '0;
            o_cpu_hold <= 1'b1;
            o_done     <= 1'b0;
            o_error    <= 1'b0;
        end else begin
            // Strobe is raised only on entry to WRITE, so it lasts exactly one cycle.
            o_wr_en <= 1'b0;

            case (state)
                IDLE: begin
                    // Non-SYNC bytes are consumed and dropped while hunting for a frame.
                    if (rxFire && i_rx_data == SYNC_BYTE) begin
                        checksum <= '0;
                        state    <= LEN_HI;
                    end
                end

                LEN_HI: begin
                    if (rxFire) begin
                        lenHi    <= i_rx_data;
                        checksum <= checksum + i_rx_data;
                        state    <= LEN_LO;
                    end
                end

                LEN_LO: begin
                    if (rxFire) begin
                        length    <= {lenHi, i_rx_data};
                        checksum  <= checksum + i_rx_data;
                        wordCount <= '0;
                        if ({16'd0, lenHi, i_rx_data} > 32'(MAX_WORDS)) begin
                            o_error    <= 1'b1;
                            o_rx_ready <= 1'b0;
                            state      <= ERROR;
                        end else if ({lenHi, i_rx_data} == 16'd0) begin
                            state <= CSUM;
                        end else begin
                            state <= B0;
                        end
                    end
                end

                B0: begin
                    if (rxFire) begin
                        // Only the two low bits carry instruction data; anything
                        // else set means a corrupt stream.
                        if (i_rx_data[0:5] != 6'd0) begin
                            o_error    <= 1'b1;
                            o_rx_ready <= 1'b0;
                            state      <= ERROR;
                        end else begin
                            b0Low    <= i_rx_data[6:7];
                            checksum <= checksum + i_rx_data;
                            state    <= B1;
                        end
                    end
                end

                B1: begin
                    if (rxFire) begin
                        b1Byte   <= i_rx_data;
                        checksum <= checksum + i_rx_data;
                        state    <= B2;
                    end
                end

                B2: begin
                    if (rxFire) begin
                        checksum   <= checksum + i_rx_data;
                        o_wr_data  <= {b0Low, b1Byte, i_rx_data};
                        o_wr_addr  <= wordCount[ADDR_W-1:0];
                        o_wr_en    <= 1'b1;
                        o_rx_ready <= 1'b0;
                        state      <= WRITE;
                    end
                end

                WRITE: begin
                    wordCount  <= wordCount + 17'd1;
                    o_rx_ready <= 1'b1;
                    state      <= (wordCount + 17'd1 == {1'b0, length}) ? CSUM : B0;
                end

                CSUM: begin
                    if (rxFire) begin
                        o_rx_ready <= 1'b0;
                        if (i_rx_data == checksum) begin
                            o_done     <= 1'b1;
                            o_cpu_hold <= 1'b0;
                            state      <= DONE;
                        end else begin
                            o_error <= 1'b1;
                            state   <= ERROR;
                        end
                    end
                end

                DONE, ERROR: begin
                    if (i_restart) begin
                        state      <= IDLE;
                        o_cpu_hold <= 1'b1;
                        o_done     <= 1'b0;
                        o_error    <= 1'b0;
                        o_rx_ready <= 1'b1;
                        wordCount  <= '0;
                        length     <= '0;
                        lenHi      <= '0;
                        checksum   <= '0;
                    end
                end

                default: begin
                    state      <= IDLE;
                    o_rx_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Directed testbench for program_loader. Expected memory writes are pushed to
// a scoreboard queue as frames are driven and popped by a write monitor.
module tb_program_loader;

    typedef struct {
        logic [15:0] addr;
        logic [17:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [0:7]  rxData;
    logic        rxValid;
    logic        rxReady;
    logic        restart;
    logic        wrEn;
    logic [0:15] wrAddr;
    logic [0:17] wrData;
    logic        cpuHold;
    logic        done;
    logic        err;

    int  checks = 0;
    int  errors = 0;
    int  writesSeen = 0;
    wr_t expQ[$];

    program_loader #(.ADDR_W(16), .MAX_WORDS(4096)) dut (
        .i_clock   (clk),
        .i_reset   (rst),
        .i_rx_data (rxData),
        .i_rx_valid(rxValid),
        .o_rx_ready(rxReady),
        .i_restart (restart),
        .o_wr_en   (wrEn),
        .o_wr_addr (wrAddr),
        .o_wr_data (wrData),
        .o_cpu_hold(cpuHold),
        .o_done    (done),
        .o_error   (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Write monitor: every strobe must match the head of the scoreboard.
    always @(negedge clk) begin
        if (wrEn === 1'b1) begin
            writesSeen++;
            if (expQ.size() == 0) begin
                check("unexpected_write", 32'(wrAddr), 32'hFFFF_FFFF);
            end else begin
                wr_t e;
                e = expQ.pop_front();
                check("wr_addr", 32'(wrAddr), 32'(e.addr));
                check("wr_data", 32'(wrData), 32'(e.data));
            end
        end
    end

    // Called at a negedge; returns at the negedge after the byte was accepted,
    // leaving valid high so back-to-back bytes stream without gaps.
    task automatic sendByte(input logic [7:0] b);
        int n = 0;
        rxData  = b;
        rxValid = 1'b1;
        while (rxReady !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            check("ready_timeout", 32'(n), 32'd0);
            rxValid = 1'b0;
        end else begin
            @(negedge clk);
        end
    endtask

    task automatic idle(input int cycles);
        rxValid = 1'b0;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic pulseRestart();
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
    endtask

    // Sends a full frame of n random words; pushes expected writes.
    task automatic loadImage(input int n, input bit badCsum);
        logic [7:0]  sum;
        logic [17:0] instr;
        logic [7:0]  b0;
        sum = 8'(n >> 8) + 8'(n);
        sendByte(8'hA5);
        sendByte(8'(n >> 8));
        sendByte(8'(n));
        for (int i = 0; i < n; i++) begin
            instr = 18'($urandom);
            b0 = {6'd0, instr[17:16]};
            expQ.push_back('{addr: 16'(i), data: instr});
            sum = sum + b0 + instr[15:8] + instr[7:0];
            sendByte(b0);
            sendByte(instr[15:8]);
            sendByte(instr[7:0]);
        end
        sendByte(badCsum ? sum + 8'd1 : sum);
        idle(1);
    endtask

    initial begin
        int w0;
        rst     = 1'b1;
        rxData  = '0;
        rxValid = 1'b0;
        restart = 1'b0;
        #1 fork begin #2ms; $display("FAIL watchdog"); $fatal(1, "timeout"); end join_none
        repeat (2) @(negedge clk);

        // Reset state
        check("rst_hold",  32'(cpuHold), 32'd1);
        check("rst_ready", 32'(rxReady), 32'd1);
        check("rst_wr_en", 32'(wrEn),    32'd0);
        check("rst_done",  32'(done),    32'd0);
        check("rst_error", 32'(err),     32'd0);
        check("rst_addr",  32'(wrAddr),  32'd0);
        check("rst_data",  32'(wrData),  32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Single word, exact bytes from the frame description
        expQ.push_back('{addr: 16'd0, data: 18'h23456});
        sendByte(8'hA5); sendByte(8'h00); sendByte(8'h01);
        sendByte(8'h02); sendByte(8'h34); sendByte(8'h56);
        check("wr_latency", 32'(wrEn), 32'd1);
        sendByte(8'h8D);
        idle(1);
        check("t1_done",  32'(done),    32'd1);
        check("t1_hold",  32'(cpuHold), 32'd0);
        check("t1_ready", 32'(rxReady), 32'd0);
        check("t1_writes", 32'(writesSeen), 32'd1);
        pulseRestart();
        check("t1_restart_hold", 32'(cpuHold), 32'd1);
        check("t1_restart_done", 32'(done),    32'd0);
        check("t1_restart_ready", 32'(rxReady), 32'd1);

        // Garbage in IDLE, then empty image
        w0 = writesSeen;
        sendByte(8'h00); sendByte(8'hFF);
        sendByte(8'hA5); sendByte(8'h00); sendByte(8'h00); sendByte(8'h00);
        idle(1);
        check("t2_done",   32'(done),       32'd1);
        check("t2_writes", 32'(writesSeen), 32'(w0));
        pulseRestart();

        // Bad checksum: all words written, then ERROR
        w0 = writesSeen;
        loadImage(3, 1'b1);
        check("t3_writes", 32'(writesSeen - w0), 32'd3);
        check("t3_error",  32'(err),     32'd1);
        check("t3_hold",   32'(cpuHold), 32'd1);
        check("t3_done",   32'(done),    32'd0);
        pulseRestart();
        check("t3_restart_error", 32'(err),     32'd0);
        check("t3_restart_ready", 32'(rxReady), 32'd1);

        // Oversized image: 4097 words
        w0 = writesSeen;
        sendByte(8'hA5); sendByte(8'h10); sendByte(8'h01);
        rxValid = 1'b0;
        check("t4_error", 32'(err),     32'd1);
        check("t4_ready", 32'(rxReady), 32'd0);
        idle(4);
        check("t4_writes", 32'(writesSeen), 32'(w0));
        pulseRestart();

        // Illegal B0 on the second word
        w0 = writesSeen;
        expQ.push_back('{addr: 16'd0, data: 18'h01234});
        sendByte(8'hA5); sendByte(8'h00); sendByte(8'h02);
        sendByte(8'h00); sendByte(8'h12); sendByte(8'h34);
        sendByte(8'h04);
        rxValid = 1'b0;
        check("t5_error", 32'(err), 32'd1);
        idle(4);
        check("t5_writes", 32'(writesSeen - w0), 32'd1);
        pulseRestart();

        // Async reset during B1 of word 3
        w0 = writesSeen;
        sendByte(8'hA5); sendByte(8'h00); sendByte(8'h05);
        for (int i = 0; i < 3; i++) begin
            logic [17:0] instr;
            instr = 18'($urandom);
            expQ.push_back('{addr: 16'(i), data: instr});
            sendByte({6'd0, instr[17:16]});
            sendByte(instr[15:8]);
            sendByte(instr[7:0]);
        end
        sendByte(8'h01);
        rxValid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("t6_hold",  32'(cpuHold), 32'd1);
        check("t6_ready", 32'(rxReady), 32'd1);
        check("t6_wr_en", 32'(wrEn),    32'd0);
        check("t6_error", 32'(err),     32'd0);
        @(negedge clk);
        rst = 1'b0;
        idle(4);
        check("t6_writes", 32'(writesSeen - w0), 32'd3);
        loadImage(2, 1'b0);
        check("t6_reload_done", 32'(done),    32'd1);
        check("t6_reload_hold", 32'(cpuHold), 32'd0);

        check("scoreboard_empty", 32'(expQ.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
